// File: rtl/fetch_stage_pkg.sv
// Shared constants, FSM encoding and opcode helper for the microRISC fetch stage.
package fetch_stage_pkg;

    localparam int          PC_WIDTH   = 9;
    localparam int          INST_WIDTH = 16;
    localparam logic [3:0]  OPC_HALT   = 4'hF;
    localparam logic [15:0] NOP_INST   = 16'h0000;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fs_state_t;

    function automatic logic is_halt(input logic [INST_WIDTH-1:0] inst,
                                     input logic [3:0]            opc);
        return inst[INST_WIDTH-1:INST_WIDTH-4] == opc;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold it, or drop only its valid bit.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int PC_W = PC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clr_valid,
    input  logic [INST_WIDTH-1:0] inst,
    input  logic [PC_W-1:0]       pc,
    input  logic [PC_W-1:0]       pc_plus1,
    output logic [INST_WIDTH-1:0] ifid_inst,
    output logic [PC_W-1:0]       ifid_pc,
    output logic [PC_W-1:0]       ifid_pc_plus1,
    output logic                  ifid_valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_inst     <= NOP_INST;
            ifid_pc       <= '0;
            ifid_pc_plus1 <= '0;
            ifid_valid    <= 1'b0;
        end else if (load) begin
            ifid_inst     <= inst;
            ifid_pc       <= pc;
            ifid_pc_plus1 <= pc_plus1;
            ifid_valid    <= 1'b1;
        end else if (clr_valid) begin
            ifid_valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, RUN/HALT FSM and IF/ID capture.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W     = PC_WIDTH,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HALT_OPC = OPC_HALT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  redirect_valid,
    input  logic [PC_W-1:0]       redirect_pc,
    output logic [PC_W-1:0]       imem_addr,
    input  logic [INST_WIDTH-1:0] imem_inst,
    output logic [INST_WIDTH-1:0] ifid_inst,
    output logic [PC_W-1:0]       ifid_pc,
    output logic [PC_W-1:0]       ifid_pc_plus1,
    output logic                  ifid_valid,
    output logic                  halted
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_inc;
    fs_state_t       state_q;
    logic            load;
    logic            clr_valid;
    logic            halt_hit;

    assign imem_addr = pc_q;
    assign pc_inc    = pc_q + 1'b1;

    // Redirect beats stall; a stalled HALT state freezes everything, including flush.
    always_comb begin
        load      = 1'b0;
        clr_valid = 1'b0;
        halt_hit  = 1'b0;
        if (redirect_valid) begin
            clr_valid = 1'b1;
        end else if (stall) begin
            clr_valid = flush && (state_q == FS_RUN);
        end else if (state_q == FS_HALT || flush) begin
            clr_valid = 1'b1;
        end else begin
            load     = 1'b1;
            halt_hit = is_halt(imem_inst, HALT_OPC);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= FS_RUN;
            halted  <= 1'b0;
        end else if (redirect_valid) begin
            pc_q    <= redirect_pc;
            state_q <= FS_RUN;
            halted  <= 1'b0;
        end else if (halt_hit) begin
            state_q <= FS_HALT;
            halted  <= 1'b1;
        end else if (!stall && state_q == FS_RUN) begin
            pc_q    <= pc_inc;
        end
    end

    fetch_stage_if_id_reg #(.PC_W(PC_W)) u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .clr_valid    (clr_valid),
        .inst         (imem_inst),
        .pc           (pc_q),
        .pc_plus1     (pc_inc),
        .ifid_inst    (ifid_inst),
        .ifid_pc      (ifid_pc),
        .ifid_pc_plus1(ifid_pc_plus1),
        .ifid_valid   (ifid_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural model pushes expected outputs per edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, redirect_valid;
    logic [8:0]  redirect_pc, imem_addr, ifid_pc, ifid_pc_plus1;
    logic [15:0] imem_inst, ifid_inst;
    logic        ifid_valid, halted;

    logic [15:0] mem [512];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [8:0]  addr;
        logic [15:0] inst;
        logic [8:0]  ipc;
        logic [8:0]  pp1;
        logic        valid;
        logic        halted;
    } exp_t;

    exp_t exp_q[$];

    // reference model state
    logic [8:0]  m_pc, m_ipc, m_pp1;
    logic [15:0] m_inst;
    logic        m_valid, m_halt;

    always #5 clk = ~clk;

    assign imem_inst = mem[imem_addr];

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_inst     (imem_inst),
        .ifid_inst     (ifid_inst),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus1 (ifid_pc_plus1),
        .ifid_valid    (ifid_valid),
        .halted        (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_tests++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, req);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic f,
                              input logic rv, input logic [8:0] rp);
        exp_t e;
        if (r) begin
            m_pc = 9'h000; m_inst = 16'h0000; m_ipc = 9'h000; m_pp1 = 9'h000;
            m_valid = 1'b0; m_halt = 1'b0;
        end else if (rv) begin
            m_pc = rp; m_valid = 1'b0; m_halt = 1'b0;
        end else if (s) begin
            if (!m_halt && f) m_valid = 1'b0;
        end else if (m_halt) begin
            m_valid = 1'b0;
        end else if (f) begin
            m_pc = m_pc + 9'd1; m_valid = 1'b0;
        end else begin
            m_inst = mem[m_pc]; m_ipc = m_pc; m_pp1 = m_pc + 9'd1; m_valid = 1'b1;
            if (m_inst[15:12] == 4'hF) m_halt = 1'b1;
            else m_pc = m_pc + 9'd1;
        end
        e.addr = m_pc; e.inst = m_inst; e.ipc = m_ipc; e.pp1 = m_pp1;
        e.valid = m_valid; e.halted = m_halt;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic s, input logic f,
                        input logic rv, input logic [8:0] rp);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; flush = f; redirect_valid = rv; redirect_pc = rp;
        model_edge(r, s, f, rv, rp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("imem_addr",     imem_addr,     e.addr);
            check("ifid_inst",     ifid_inst,     e.inst);
            check("ifid_pc",       ifid_pc,       e.ipc);
            check("ifid_pc_plus1", ifid_pc_plus1, e.pp1);
            check("ifid_valid",    ifid_valid,    e.valid);
            check("halted",        halted,        e.halted);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = {4'(i % 15), 12'(i)};
        mem[0] = 16'hA001; mem[1] = 16'hB002; mem[2] = 16'hC003; mem[3] = 16'hD004;
        mem[9'h040] = 16'h1234;
        mem[4] = 16'h2004; mem[5] = 16'hF000;
        mem[9'h010] = 16'h5010;
        mem[9'h1FF] = 16'h71FF;
        mem[9'h020] = 16'hF000;
        m_pc = '0; m_ipc = '0; m_pp1 = '0; m_inst = '0; m_valid = 1'b0; m_halt = 1'b0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        // 1: reset then straight-line fetch
        step(1'b1, 1'b0, 1'b0, 1'b0, 9'h000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 9'h000);
        check("rst_addr",  imem_addr,  9'h000);
        check("rst_valid", ifid_valid, 1'b0);
        check("rst_inst",  ifid_inst,  16'h0000);
        run(1);
        check("t1_inst", ifid_inst, 16'hA001);
        check("t1_addr", imem_addr, 9'h001);
        run(1);
        check("t1_inst_b", ifid_inst, 16'hB002);
        check("t1_pp1",    ifid_pc_plus1, 9'h002);

        // 2: three-cycle stall at PC=2, then release
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 9'h000);
        check("t2_hold_addr", imem_addr, 9'h002);
        check("t2_hold_inst", ifid_inst, 16'hB002);
        check("t2_hold_vld",  ifid_valid, 1'b1);
        run(1);
        check("t2_rel_inst", ifid_inst, 16'hC003);
        check("t2_rel_addr", imem_addr, 9'h003);

        // 3: redirect wins over simultaneous stall
        step(1'b0, 1'b1, 1'b0, 1'b1, 9'h040);
        check("t3_addr", imem_addr, 9'h040);
        check("t3_vld",  ifid_valid, 1'b0);
        run(1);
        check("t3_inst", ifid_inst, 16'h1234);

        // 4: HALT capture, stalled HALT, exit by redirect
        step(1'b0, 1'b0, 1'b0, 1'b1, 9'h004);
        run(2);
        check("t4_halt_inst", ifid_inst, 16'hF000);
        check("t4_halt_pc",   ifid_pc,   9'h005);
        check("t4_halted",    halted,    1'b1);
        check("t4_addr",      imem_addr, 9'h005);
        step(1'b0, 1'b1, 1'b1, 1'b0, 9'h000);
        check("t4_stall_vld", ifid_valid, 1'b1);
        run(2);
        check("t4_vld_drop", ifid_valid, 1'b0);
        check("t4_stuck",    imem_addr,  9'h005);
        step(1'b0, 1'b0, 1'b0, 1'b1, 9'h010);
        check("t4_resume_h", halted,    1'b0);
        check("t4_resume_a", imem_addr, 9'h010);
        run(1);
        check("t4_resume_i", ifid_inst, 16'h5010);

        // 5: PC wrap at top of address space
        step(1'b0, 1'b0, 1'b0, 1'b1, 9'h1FF);
        run(1);
        check("t5_pc",   ifid_pc,       9'h1FF);
        check("t5_pp1",  ifid_pc_plus1, 9'h000);
        check("t5_addr", imem_addr,     9'h000);

        // 6: flushed HALT word is ignored; reset out of HALT with redirect present
        step(1'b0, 1'b0, 1'b0, 1'b1, 9'h020);
        step(1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
        check("t6_vld",    ifid_valid, 1'b0);
        check("t6_halted", halted,     1'b0);
        check("t6_addr",   imem_addr,  9'h021);
        step(1'b0, 1'b0, 1'b0, 1'b1, 9'h020);
        run(1);
        check("t6_halt", halted, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 9'h0AA);
        check("t6_rst_halted", halted,     1'b0);
        check("t6_rst_addr",   imem_addr,  9'h000);
        check("t6_rst_inst",   ifid_inst,  16'h0000);
        check("t6_rst_pc",     ifid_pc,    9'h000);

        // random mix with a few HALT words sprinkled in
        for (int i = 0; i < 8; i++) mem[$urandom_range(0, 63)] = 16'hF0F0;
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                 9'($urandom_range(0, 63)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
